// File: rtl/mips_pkg.sv
// +----------------------------------------------------------------------+
// | mips_pkg : shared MIPS funct codes, MDU types and sign helpers       |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
`default_nettype none

package mips_pkg;

   localparam int XLEN = 32;

   localparam logic [5:0] FUNCT_MFHI  = 6'b010000;
   localparam logic [5:0] FUNCT_MFLO  = 6'b010010;
   localparam logic [5:0] FUNCT_MULT  = 6'b011000;
   localparam logic [5:0] FUNCT_MULTU = 6'b011001;
   localparam logic [5:0] FUNCT_DIV   = 6'b011010;
   localparam logic [5:0] FUNCT_DIVU  = 6'b011011;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      FIX  = 2'd2
   } mdu_state_t;

   typedef enum logic [1:0] {
      MUL_S = 2'd0,
      MUL_U = 2'd1,
      DIV_S = 2'd2,
      DIV_U = 2'd3
   } mdu_op_t;

   // Conditional two's-complement negate; with n = sign bit it yields |v|.
   function automatic logic [XLEN-1:0] cond_neg_w(input logic [XLEN-1:0] v, input logic n);
      return n ? -v : v;
   endfunction

   function automatic logic [2*XLEN-1:0] cond_neg_d(input logic [2*XLEN-1:0] v, input logic n);
      return n ? -v : v;
   endfunction

endpackage

`default_nettype wire

// File: rtl/mult_div_unit_if.sv
// +----------------------------------------------------------------------+
// | mult_div_unit_if : issue / HI-LO read bundle between pipeline and MDU |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
`default_nettype none

interface mult_div_unit_if #(
   parameter int WIDTH = 32
);
   logic             start;
   logic [5:0]       funct;
   logic [WIDTH-1:0] rs_val;
   logic [WIDTH-1:0] rt_val;
   logic             mf_req;
   logic             mf_sel;
   logic [WIDTH-1:0] rd_data;
   logic [WIDTH-1:0] hi;
   logic [WIDTH-1:0] lo;
   logic             busy;
   logic             done;
   logic             stall;

   modport master (
      output start, funct, rs_val, rt_val, mf_req, mf_sel,
      input  rd_data, hi, lo, busy, done, stall
   );

   modport slave (
      input  start, funct, rs_val, rt_val, mf_req, mf_sel,
      output rd_data, hi, lo, busy, done, stall
   );
endinterface

`default_nettype wire

// File: rtl/mult_div_unit.sv
// +----------------------------------------------------------------------+
// | mult_div_unit : iterative shift-add multiply / restoring divide, HI/LO|
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
`default_nettype none

module mult_div_unit
   import mips_pkg::*;
#(
   parameter int WIDTH = XLEN
) (
   input  wire logic         clk,
   input  wire logic         rst,
   mult_div_unit_if.slave    bus
);

   localparam int CW = $clog2(WIDTH + 1);

   mdu_state_t         r_state, w_next;
   mdu_op_t            r_op, w_op;
   logic [CW-1:0]      r_cnt;
   logic [WIDTH-1:0]   r_opa, r_hi, r_lo;
   logic [2*WIDTH-1:0] r_acc;
   logic               r_neg_q, r_neg_r, r_div_zero, r_done;

   logic               w_legal, w_signed, w_is_div, w_rs_neg, w_rt_neg;
   logic [WIDTH-1:0]   w_rs_abs, w_rt_abs;
   logic               w_run_div, w_busy;
   logic [WIDTH:0]     w_x, w_y;
   logic [WIDTH+1:0]   w_alu;
   logic [2*WIDTH-1:0] w_prod;
   logic [WIDTH-1:0]   w_quot, w_rem;

   always_comb begin
      w_legal = 1'b1;
      w_op    = MUL_S;
      case (bus.funct)
         FUNCT_MULT:  w_op = MUL_S;
         FUNCT_MULTU: w_op = MUL_U;
         FUNCT_DIV:   w_op = DIV_S;
         FUNCT_DIVU:  w_op = DIV_U;
         default:     w_legal = 1'b0;
      endcase
   end

   assign w_signed = (w_op == MUL_S) || (w_op == DIV_S);
   assign w_is_div = (w_op == DIV_S) || (w_op == DIV_U);
   assign w_rs_neg = w_signed & bus.rs_val[WIDTH-1];
   assign w_rt_neg = w_signed & bus.rt_val[WIDTH-1];
   assign w_rs_abs = cond_neg_w(bus.rs_val, w_rs_neg);
   assign w_rt_abs = cond_neg_w(bus.rt_val, w_rt_neg);

   // One adder/subtractor: multiply adds into the upper half, divide trial-subtracts
   // the divisor from the left-shifted partial remainder.
   assign w_run_div = (r_op == DIV_S) || (r_op == DIV_U);
   assign w_x       = w_run_div ? r_acc[2*WIDTH-1:WIDTH-1] : {1'b0, r_acc[2*WIDTH-1:WIDTH]};
   assign w_y       = {1'b0, r_opa};
   assign w_alu     = w_run_div ? ({1'b0, w_x} - {1'b0, w_y}) : ({1'b0, w_x} + {1'b0, w_y});

   assign w_prod = cond_neg_d(r_acc, r_neg_q);
   assign w_quot = r_div_zero ? {WIDTH{1'b1}} : cond_neg_w(r_acc[WIDTH-1:0], r_neg_q);
   assign w_rem  = cond_neg_w(r_acc[2*WIDTH-1:WIDTH], r_neg_r);

   always_ff @(posedge clk) begin
      if (rst) r_state <= IDLE;
      else     r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE:    if (bus.start && w_legal) w_next = RUN;
         RUN:     if (r_cnt == CW'(1)) w_next = FIX;
         FIX:     w_next = IDLE;
         default: w_next = IDLE;
      endcase
   end

   always_comb begin
      w_busy = (r_state == RUN) || (r_state == FIX);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_op       <= MUL_S;
         r_cnt      <= '0;
         r_opa      <= '0;
         r_acc      <= '0;
         r_neg_q    <= 1'b0;
         r_neg_r    <= 1'b0;
         r_div_zero <= 1'b0;
         r_hi       <= '0;
         r_lo       <= '0;
         r_done     <= 1'b0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            IDLE: begin
               if (bus.start && w_legal) begin
                  r_op       <= w_op;
                  r_cnt      <= CW'(WIDTH);
                  r_neg_q    <= w_rs_neg ^ w_rt_neg;
                  r_neg_r    <= w_rs_neg;
                  r_div_zero <= w_is_div && (bus.rt_val == '0);
                  r_opa      <= w_is_div ? w_rt_abs : w_rs_abs;
                  r_acc      <= {{WIDTH{1'b0}}, (w_is_div ? w_rs_abs : w_rt_abs)};
               end
            end
            RUN: begin
               r_cnt <= r_cnt - CW'(1);
               if (w_run_div) begin
                  if (w_alu[WIDTH+1]) r_acc <= {w_x[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b0};
                  else                r_acc <= {w_alu[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b1};
               end else begin
                  if (r_acc[0]) r_acc <= {w_alu[WIDTH:0], r_acc[WIDTH-1:1]};
                  else          r_acc <= {1'b0, r_acc[2*WIDTH-1:1]};
               end
            end
            FIX: begin
               r_done <= 1'b1;
               if (w_run_div) begin
                  r_hi <= w_rem;
                  r_lo <= w_quot;
               end else begin
                  r_hi <= w_prod[2*WIDTH-1:WIDTH];
                  r_lo <= w_prod[WIDTH-1:0];
               end
            end
            default: ;
         endcase
      end
   end

   assign bus.hi      = r_hi;
   assign bus.lo      = r_lo;
   assign bus.busy    = w_busy;
   assign bus.done    = r_done;
   assign bus.stall   = w_busy & bus.mf_req;
   assign bus.rd_data = bus.mf_sel ? r_lo : r_hi;

endmodule

`default_nettype wire

// File: tb/tb_mult_div_unit.sv
// +----------------------------------------------------------------------+
// | tb_mult_div_unit : directed vectors with a queue-based HI/LO scoreboard|
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
`default_nettype none

module tb_mult_div_unit;
   import mips_pkg::*;

   localparam int W = 32;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   mult_div_unit_if #(.WIDTH(W)) bus ();

   mult_div_unit #(.WIDTH(W)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   typedef struct {
      logic [31:0] hi;
      logic [31:0] lo;
      int          acc_edge;
      string       nm;
   } exp_t;

   exp_t sb[$];
   int   n_vec  = 0;
   int   n_miss = 0;
   int   edges  = 0;

   always @(posedge clk) edges <= edges + 1;

   function automatic void ck(string nm, logic [31:0] act, logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_miss++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endfunction

   // Monitor: every done pulse must match the oldest outstanding expectation.
   always @(negedge clk) begin
      if (!rst && bus.done) begin
         if (sb.size() == 0) begin
            n_vec++;
            n_miss++;
            $display("FAIL unexpected_done: got done=1 expected no pending op");
         end else begin
            exp_t e;
            e = sb.pop_front();
            ck({e.nm, "_hi"}, bus.hi, e.hi);
            ck({e.nm, "_lo"}, bus.lo, e.lo);
            ck({e.nm, "_latency"}, 32'(edges - e.acc_edge), 32'(W + 1));
         end
      end
   end

   task automatic issue(input string nm, input logic [5:0] f, input logic [31:0] rs,
                        input logic [31:0] rt, input logic push,
                        input logic [31:0] ehi, input logic [31:0] elo);
      exp_t e;
      bus.start  = 1'b1;
      bus.funct  = f;
      bus.rs_val = rs;
      bus.rt_val = rt;
      @(posedge clk);
      #1;
      if (push) begin
         e.hi = ehi; e.lo = elo; e.acc_edge = edges; e.nm = nm;
         sb.push_back(e);
      end
      bus.start = 1'b0;
   endtask

   // Returns at the negedge of the done cycle, or flags a timeout.
   task automatic wait_done(input string nm);
      for (int i = 0; i < 60; i++) begin
         @(negedge clk);
         if (bus.done) return;
      end
      ck({nm, "_timeout"}, 32'(0), 32'(1));
   endtask

   initial begin
      int stall_bad;
      int seen_done;
      bus.start  = 1'b0;
      bus.funct  = '0;
      bus.rs_val = '0;
      bus.rt_val = '0;
      bus.mf_req = 1'b0;
      bus.mf_sel = 1'b0;

      repeat (3) @(posedge clk);
      @(negedge clk);
      ck("rst_hi", bus.hi, 32'h0);
      ck("rst_lo", bus.lo, 32'h0);
      ck("rst_busy", 32'(bus.busy), 32'(0));
      ck("rst_done", 32'(bus.done), 32'(0));
      rst = 1'b0;
      @(posedge clk); #1;

      // Signed multiply with mflo held from cycle 2 and an ignored start at cycle 5.
      issue("mult_7_m3", FUNCT_MULT, 32'h00000007, 32'hFFFFFFFD, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFEB);
      @(posedge clk); #1;
      bus.mf_req = 1'b1;
      bus.mf_sel = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      issue("ignored", FUNCT_DIVU, 32'h1, 32'h1, 1'b0, 32'h0, 32'h0);
      stall_bad = 0;
      seen_done = 0;
      for (int i = 0; i < 60 && seen_done == 0; i++) begin
         @(negedge clk);
         if (bus.done) seen_done = 1;
         else if (!bus.stall) stall_bad++;
      end
      ck("mult_done_seen", 32'(seen_done), 32'(1));
      ck("stall_while_busy", 32'(stall_bad), 32'(0));
      ck("stall_in_done", 32'(bus.stall), 32'(0));
      ck("rd_data_new_lo", bus.rd_data, 32'hFFFFFFEB);
      bus.mf_req = 1'b0;

      // Back-to-back issue in the done cycle.
      issue("multu_max", FUNCT_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 32'hFFFFFFFE, 32'h00000001);
      wait_done("multu_max");

      // Read-before-issue in the same IDLE cycle returns the old HI.
      bus.mf_req = 1'b1;
      bus.mf_sel = 1'b0;
      #1;
      ck("idle_read_stall", 32'(bus.stall), 32'(0));
      ck("idle_read_old_hi", bus.rd_data, 32'hFFFFFFFE);
      issue("div_m7_2", FUNCT_DIV, 32'hFFFFFFF9, 32'h00000002, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFFD);
      ck("stall_after_issue", 32'(bus.stall), 32'(1));
      bus.mf_req = 1'b0;
      wait_done("div_m7_2");

      issue("div_ovf", FUNCT_DIV, 32'h80000000, 32'hFFFFFFFF, 1'b1, 32'h00000000, 32'h80000000);
      wait_done("div_ovf");
      issue("divu_100_0", FUNCT_DIVU, 32'd100, 32'h0, 1'b1, 32'h00000064, 32'hFFFFFFFF);
      wait_done("divu_100_0");
      issue("div_m7_0", FUNCT_DIV, 32'hFFFFFFF9, 32'h0, 1'b1, 32'hFFFFFFF9, 32'hFFFFFFFF);
      wait_done("div_m7_0");
      issue("div_7_m2", FUNCT_DIV, 32'h00000007, 32'hFFFFFFFE, 1'b1, 32'h00000001, 32'hFFFFFFFD);
      wait_done("div_7_m2");
      issue("multu_shift", FUNCT_MULTU, 32'h12345678, 32'h00000010, 1'b1, 32'h00000001, 32'h23456780);
      wait_done("multu_shift");
      issue("mult_m1_m1", FUNCT_MULT, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 32'h00000000, 32'h00000001);
      wait_done("mult_m1_m1");
      issue("divu_big", FUNCT_DIVU, 32'hFFFFFFFF, 32'h00000010, 1'b1, 32'h0000000F, 32'h0FFFFFFF);
      wait_done("divu_big");

      // A start with a non-MDU funct must not leave IDLE.
      issue("illegal", FUNCT_MFHI, 32'h5, 32'h5, 1'b0, 32'h0, 32'h0);
      ck("illegal_not_busy", 32'(bus.busy), 32'(0));

      // Reset at cycle 10 of an op aborts it without a done pulse.
      issue("abort", FUNCT_MULT, 32'h5, 32'h5, 1'b0, 32'h0, 32'h0);
      repeat (9) @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk);
      @(negedge clk);
      ck("abort_busy", 32'(bus.busy), 32'(0));
      ck("abort_done", 32'(bus.done), 32'(0));
      ck("abort_hi", bus.hi, 32'h0);
      ck("abort_lo", bus.lo, 32'h0);
      rst = 1'b0;
      seen_done = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (bus.done) seen_done = 1;
      end
      ck("abort_no_done", 32'(seen_done), 32'(0));
      ck("scoreboard_drained", 32'(sb.size()), 32'(0));

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule

`default_nettype wire
